// File: rtl/pow_pkg.sv
// Shared widths and helpers for the round-robin power pipeline.
// Latency: none (package only).
// Backpressure: none (package only).
package pow_pkg;

    localparam int OP_W  = 7;
    localparam int RES_W = 64;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One squaring stage: full product, truncated to the result width.
    function automatic logic [RES_W-1:0] sq64(input logic [RES_W-1:0] x);
        return x * x;
    endfunction

endpackage

// File: rtl/pow_tag_pipe.sv
// Squaring pipeline: out = in^(2^LATENCY) mod 2^64, with valid and requester id riding alongside.
// Latency: LATENCY cycles from in_vld to out_vld.
// Backpressure: none; the caller only launches when a result slot is guaranteed downstream.
module pow_tag_pipe
    import pow_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int ID_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [OP_W-1:0]  in_dat,
    input  logic [ID_W-1:0]  in_id,
    output logic             out_vld,
    output logic [RES_W-1:0] out_dat,
    output logic [ID_W-1:0]  out_id
);

    logic             r_vld [LATENCY];
    logic [RES_W-1:0] r_dat [LATENCY];
    logic [ID_W-1:0]  r_id  [LATENCY];

    // Valid chain: the only state that must be cleared so reset drops in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) r_vld[s] <= 1'b0;
        end else begin
            r_vld[0] <= in_vld;
            for (int s = 1; s < LATENCY; s++) r_vld[s] <= r_vld[s-1];
        end
    end

    // Datapath and id sideband: one squaring per stage, no reset needed.
    always_ff @(posedge clk) begin
        r_dat[0] <= sq64({{(RES_W-OP_W){1'b0}}, in_dat});
        r_id[0]  <= in_id;
        for (int s = 1; s < LATENCY; s++) begin
            r_dat[s] <= sq64(r_dat[s-1]);
            r_id[s]  <= r_id[s-1];
        end
    end

    assign out_vld = r_vld[LATENCY-1];
    assign out_dat = r_dat[LATENCY-1];
    assign out_id  = r_id[LATENCY-1];

endmodule

// File: rtl/pow_arbiter.sv
// Round-robin arbiter feeding a shared power pipeline, with a credit-guarded show-ahead result FIFO.
// Latency: rsp_valid rises LATENCY+1 cycles after the accept cycle.
// Backpressure: credits equal FIFO_DEPTH; all req_ready drop while every slot is spoken for.
module pow_arbiter
    import pow_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*OP_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RES_W-1:0]         rsp_data,
    output logic [id_w(NUM_REQ)-1:0] rsp_id,
    output logic                     busy
);

    localparam int ID_W = id_w(NUM_REQ);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [ID_W-1:0]  r_ptr;
    logic [CW-1:0]    r_out;
    logic [RES_W-1:0] r_mem_dat [FIFO_DEPTH];
    logic [ID_W-1:0]  r_mem_id  [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;

    logic               w_found;
    logic               w_credit;
    logic               w_acc;
    logic               w_pop;
    logic               w_wr;
    logic [ID_W-1:0]    w_win_id;
    logic [OP_W-1:0]    w_win_dat;
    logic [NUM_REQ-1:0] w_grant;
    logic [RES_W-1:0]   w_pipe_dat;
    logic [ID_W-1:0]    w_pipe_id;

    // A pop this cycle does not return its credit until the counter updates.
    assign w_credit = (r_out != CW'(FIFO_DEPTH));

    // Round-robin search from the pointer upward with wrap; first valid requester wins.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_win_id = '0;
        w_grant  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_win_id = ID_W'(idx);
            end
        end
        if (w_found && w_credit && !rst) w_grant[w_win_id] = 1'b1;
    end

    assign req_ready = w_grant;
    assign w_acc     = |(req_valid & w_grant);
    assign w_win_dat = req_data[int'(w_win_id)*OP_W +: OP_W];

    // Pointer moves past the winner on an accept and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_acc) begin
            r_ptr <= (w_win_id == ID_W'(NUM_REQ-1)) ? '0 : w_win_id + 1'b1;
        end
    end

    // Outstanding count covers both pipeline and FIFO occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            case ({w_acc, w_pop})
                2'b10:   r_out <= r_out + 1'b1;
                2'b01:   r_out <= r_out - 1'b1;
                default: r_out <= r_out;
            endcase
        end
    end

    pow_tag_pipe #(
        .LATENCY (LATENCY),
        .ID_W    (ID_W)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (w_acc),
        .in_dat  (w_win_dat),
        .in_id   (w_win_id),
        .out_vld (w_wr),
        .out_dat (w_pipe_dat),
        .out_id  (w_pipe_id)
    );

    assign rsp_valid = (r_cnt != '0) && !rst;
    assign w_pop     = rsp_valid && rsp_ready;
    assign rsp_data  = r_mem_dat[r_rd_ptr];
    assign rsp_id    = r_mem_id[r_rd_ptr];
    assign busy      = (r_out != '0) && !rst;

    // FIFO pointers and occupancy; reset discards anything buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // FIFO storage: written straight from the pipeline output.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_dat[r_wr_ptr] <= w_pipe_dat;
            r_mem_id[r_wr_ptr]  <= w_pipe_id;
        end
    end

    // Credit accounting must make overflow and empty pops impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_wr && r_cnt == CW'(FIFO_DEPTH)));
            assert (!(w_pop && r_cnt == '0));
        end
    end

endmodule

// File: tb/tb_pow_arbiter.sv
module tb_pow_arbiter;

    localparam int NREQ  = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [27:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    typedef struct {
        longint unsigned dat;
        int              id;
        int              due;
    } exp_t;

    exp_t sb[$];
    int   m_ptr    = 0;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pow_arbiter #(
        .NUM_REQ    (NREQ),
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // Reference result: x multiplied by itself 2^LAT times, wrapping at 2^64.
    function automatic longint unsigned pow_ref(input int x);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < (1 << LAT); i++) r = r * longint'(x);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Request side: predict the grant, check handshake outputs, push expected results.
    always @(negedge clk) begin
        int         win;
        logic [3:0] emask;
        cyc++;
        if (rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            sb.delete();
            m_ptr = 0;
        end else begin
            win = -1;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (win < 0 && req_valid[i]) win = i;
            end
            emask = (win >= 0 && sb.size() < DEPTH) ? 4'(1 << win) : 4'b0;
            chk("req_ready", 64'(req_ready), 64'(emask));
            chk("busy", 64'(busy), 64'(sb.size() != 0));
            if (emask != 4'b0) begin
                sb.push_back('{pow_ref(int'(req_data[win*7 +: 7])), win, cyc + LAT + 1});
                m_ptr = (win + 1) % NREQ;
            end
        end
    end

    // Response side: rsp_valid timing, head contents (also while stalled), pops.
    always @(negedge clk) begin
        logic ev;
        #1;
        if (!rst) begin
            ev = (sb.size() > 0) && (sb[0].due <= cyc);
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            if (rsp_valid && ev) begin
                chk("rsp_data", rsp_data, sb[0].dat);
                chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [27:0] d, input logic rr, input int n);
        req_valid = v;
        req_data  = d;
        rsp_ready = rr;
        repeat (n) tick();
    endtask

    function automatic logic [27:0] pack(input int d0, input int d1, input int d2, input int d3);
        return {7'(d3), 7'(d2), 7'(d1), 7'(d0)};
    endfunction

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Single op from requester 0 in the first cycle after reset: 3 -> 6561.
        drive(4'b0001, pack(3, 0, 0, 0), 1'b1, 1);
        drive(4'b0000, '0, 1'b1, 8);

        // All requesters valid continuously.
        repeat (12) drive(4'b1111, 28'($urandom), 1'b1, 1);
        drive(4'b0000, '0, 1'b1, 8);

        // Consumer stalled while requester 1 streams, then released.
        repeat (10) drive(4'b0010, 28'($urandom), 1'b0, 1);
        repeat (12) drive(4'b0010, 28'($urandom), 1'b1, 1);
        drive(4'b0000, '0, 1'b1, 8);

        // Arithmetic corner operands.
        drive(4'b0100, pack(0, 0, 100, 0), 1'b1, 1);
        drive(4'b0100, pack(0, 0, 0, 0), 1'b1, 1);
        drive(4'b0100, pack(0, 0, 1, 0), 1'b1, 1);
        drive(4'b0100, pack(0, 0, 127, 0), 1'b1, 1);
        drive(4'b0000, '0, 1'b1, 8);

        // Pointer to 2, then only 0 and 3 valid: expect 3 then 0.
        drive(4'b0010, 28'($urandom), 1'b1, 1);
        drive(4'b1001, 28'($urandom), 1'b1, 2);
        drive(4'b0000, '0, 1'b1, 8);

        // Reset with three operations in flight.
        repeat (3) drive(4'b1111, 28'($urandom), 1'b1, 1);
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(4'b0000, '0, 1'b1, 10);

        // Random traffic with occasional resets.
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive(4'($urandom), 28'($urandom), ($urandom_range(0, 3) != 0), 1);
        end
        rst = 1'b0;

        // Bounded drain of anything still expected.
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && sb.size() != 0; c++) tick();
        drive(4'b0000, '0, 1'b1, 2);
        chk("drain_left", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
